// File: rtl/dk_sound_pkg.sv
// Shared constants and types for the discrete sound trigger path.
package dk_sound_pkg;

  localparam int TRIG_WALK  = 0;
  localparam int TRIG_JUMP  = 1;
  localparam int TRIG_STOMP = 2;

  // Logic level that turns a downstream 5 V discrete enable on.
  localparam logic EN_LEVEL_5V = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } hold_state_t;

endpackage

// File: rtl/dk_sound_trigger_latch_if.sv
// Sound-CPU port-write bus into the trigger latch, with status readback.
interface dk_sound_trigger_latch_if #(
  parameter int NUM_TRIG = 3
);
  logic                cpu_wr;
  logic [2:0]          cpu_addr;
  logic                cpu_data;
  logic                cpu_clr;
  logic [NUM_TRIG-1:0] cpu_rdata;

  modport master (output cpu_wr, cpu_addr, cpu_data, cpu_clr, input  cpu_rdata);
  modport slave  (input  cpu_wr, cpu_addr, cpu_data, cpu_clr, output cpu_rdata);
endinterface

// File: rtl/dk_sound_trigger_latch_trigger_hold_fsm.sv
// One trigger channel: stretches its enable to MIN_HOLD_SAMPLES audio ticks.
// Advances only on tick; en is registered, so it changes one clk after a tick.
module trigger_hold_fsm
  import dk_sound_pkg::*;
#(
  parameter int MIN_HOLD_SAMPLES = 64
) (
  input  logic clk,
  input  logic I_RSTn,
  input  logic tick,
  input  logic latch_bit,
  input  logic seen_bit,
  output logic seen_clr,
  output logic en
);

  localparam int CNT_W = $clog2(MIN_HOLD_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD_SAMPLES - 1);

  hold_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             en_q, en_d;
  logic             hold_done;

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    // Compared against the count before this tick's increment.
    hold_done = (cnt_q >= HOLD_LAST);
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (latch_bit || seen_bit) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end
        end
        ACTIVE: begin
          cnt_d = cnt_inc;
          if (!latch_bit) state_d = hold_done ? IDLE : HOLD;
        end
        HOLD: begin
          if (latch_bit || seen_bit) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (hold_done) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    en_d     = (state_d != IDLE) ? EN_LEVEL_5V : ~EN_LEVEL_5V;
    // seen is sampled on every tick, so every tick consumes it.
    seen_clr = tick;
    en       = en_q;
  end

endmodule

// File: rtl/dk_sound_trigger_latch.sv
// Addressable trigger latch (74LS259 style) with per-channel enable stretching.
// cpu_rdata follows a write after one clk; trig_en moves one clk after an audio tick.
module dk_sound_trigger_latch
  import dk_sound_pkg::*;
#(
  parameter int CLOCK_RATE       = 1000000,
  parameter int SAMPLE_RATE      = 48000,
  parameter int NUM_TRIG         = 3,
  parameter int MIN_HOLD_SAMPLES = 64
) (
  input  logic                     clk,
  input  logic                     I_RSTn,
  input  logic                     audio_clk_en,
  dk_sound_trigger_latch_if.slave  cpu,
  output logic [NUM_TRIG-1:0]      trig_en
);

  localparam int TICK_DIV = CLOCK_RATE / SAMPLE_RATE;

  logic [NUM_TRIG-1:0] latch_q, latch_d;
  logic [NUM_TRIG-1:0] seen_q, seen_d;
  logic [NUM_TRIG-1:0] wr_sel, seen_set, seen_clr;

  // Out-of-range addresses select nothing, so they leave all state untouched.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      wr_sel[i] = cpu.cpu_wr && (cpu.cpu_addr == 3'(i));
    end
  end

  always_comb begin
    latch_d  = latch_q;
    seen_set = wr_sel & {NUM_TRIG{cpu.cpu_data}};
    if (cpu.cpu_clr) begin
      latch_d = '0;
    end else begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (wr_sel[i]) latch_d[i] = cpu.cpu_data;
      end
    end
    // A clear leaves seen alone so a trigger already started still sounds.
    seen_d = (seen_q & ~seen_clr) | seen_set;
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      latch_q <= '0;
      seen_q  <= '0;
    end else begin
      latch_q <= latch_d;
      seen_q  <= seen_d;
    end
  end

  assign cpu.cpu_rdata = latch_q;

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_chan
    trigger_hold_fsm #(
      .MIN_HOLD_SAMPLES (MIN_HOLD_SAMPLES)
    ) u_fsm (
      .clk       (clk),
      .I_RSTn    (I_RSTn),
      .tick      (audio_clk_en),
      .latch_bit (latch_q[g]),
      .seen_bit  (seen_q[g]),
      .seen_clr  (seen_clr[g]),
      .en        (trig_en[g])
    );
  end

  if (TICK_DIV >= 2) begin : g_tick_chk
    a_tick_single : assert property (@(posedge clk) disable iff (!I_RSTn)
      audio_clk_en |=> !audio_clk_en);
  end

endmodule

// File: tb/tb_dk_sound_trigger_latch.sv
// Directed bench: stimulus queues expected trig_en edges, a monitor checks each edge.
module tb_dk_sound_trigger_latch;

  localparam int NT = 3;

  logic          clk = 1'b0;
  logic          I_RSTn = 1'b0;
  logic          audio_clk_en = 1'b0;
  logic [NT-1:0] trig_en;

  dk_sound_trigger_latch_if #(.NUM_TRIG(NT)) cpu_if ();

  dk_sound_trigger_latch #(
    .CLOCK_RATE       (1000000),
    .SAMPLE_RATE      (48000),
    .NUM_TRIG         (NT),
    .MIN_HOLD_SAMPLES (64)
  ) dut (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .audio_clk_en (audio_clk_en),
    .cpu          (cpu_if),
    .trig_en      (trig_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            tick;
    logic [NT-1:0] val;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            tick_cnt = 0;
  bit            edge_tick = 1'b0;
  logic [NT-1:0] prev_en = '0;

  // One-clk audio strobe every 20 clks.
  initial begin
    forever begin
      repeat (19) @(posedge clk);
      #1 audio_clk_en = 1'b1;
      @(posedge clk);
      #1 audio_clk_en = 1'b0;
    end
  end

  always @(posedge clk) begin
    edge_tick = audio_clk_en;
    if (audio_clk_en) tick_cnt++;
  end

  // Every trig_en change outside reset must match the next queued edge.
  always @(negedge clk) begin
    exp_t e;
    if (!I_RSTn) begin
      prev_en = trig_en;
    end else if (trig_en !== prev_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL trig_en_unexpected_edge tick=%0d actual=%b required=%b",
                 tick_cnt, trig_en, prev_en);
      end else begin
        e = exp_q.pop_front();
        if (!(edge_tick && tick_cnt == e.tick && trig_en === e.val)) begin
          errors++;
          $display("FAIL trig_en_edge actual tick=%0d on_tick=%0b val=%b required tick=%0d val=%b",
                   tick_cnt, edge_tick, trig_en, e.tick, e.val);
        end
      end
      prev_en = trig_en;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [NT-1:0] act, input logic [NT-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic expect_edge(input int t, input logic [NT-1:0] v);
    exp_t e;
    e.tick = t;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; the write is sampled on the following posedge.
  task automatic cpu_write(input logic [2:0] a, input logic d, input logic c);
    cpu_if.cpu_wr   = 1'b1;
    cpu_if.cpu_addr = a;
    cpu_if.cpu_data = d;
    cpu_if.cpu_clr  = c;
    @(negedge clk);
    cpu_if.cpu_wr  = 1'b0;
    cpu_if.cpu_clr = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (tick_cnt < t) @(negedge clk);
  endtask

  initial begin
    int t;
    cpu_if.cpu_wr   = 1'b0;
    cpu_if.cpu_addr = 3'd0;
    cpu_if.cpu_data = 1'b0;
    cpu_if.cpu_clr  = 1'b0;
    I_RSTn = 1'b0;
    repeat (3) @(negedge clk);
    I_RSTn = 1'b1;

    // 1: idle after reset
    t = tick_cnt;
    wait_until(t + 10);
    check("reset_trig_en", trig_en, 3'b000);
    check("reset_rdata", cpu_if.cpu_rdata, 3'b000);

    // 2: long hold on walk
    t = tick_cnt;
    expect_edge(t + 1, 3'b001);
    cpu_write(3'd0, 1'b1, 1'b0);
    check("s2_rdata_set", cpu_if.cpu_rdata, 3'b001);
    check("s2_no_early_rise", trig_en, 3'b000);
    wait_until(t + 100);
    expect_edge(t + 101, 3'b000);
    cpu_write(3'd0, 1'b0, 1'b0);
    check("s2_rdata_clr", cpu_if.cpu_rdata, 3'b000);
    check("s2_still_high", trig_en, 3'b001);
    wait_until(t + 105);

    // 3: sub-tick pulse on jump
    t = tick_cnt;
    expect_edge(t + 1, 3'b010);
    expect_edge(t + 65, 3'b000);
    cpu_write(3'd1, 1'b1, 1'b0);
    cpu_write(3'd1, 1'b0, 1'b0);
    check("s3_rdata", cpu_if.cpu_rdata, 3'b000);
    wait_until(t + 70);

    // 4: retrigger stomp during hold
    t = tick_cnt;
    expect_edge(t + 1, 3'b100);
    expect_edge(t + 95, 3'b000);
    cpu_write(3'd2, 1'b1, 1'b0);
    cpu_write(3'd2, 1'b0, 1'b0);
    wait_until(t + 30);
    cpu_write(3'd2, 1'b1, 1'b0);
    cpu_write(3'd2, 1'b0, 1'b0);
    check("s4_rdata", cpu_if.cpu_rdata, 3'b000);
    wait_until(t + 66);
    check("s4_extended", trig_en, 3'b100);
    wait_until(t + 100);

    // 5: out-of-range addresses, then clear racing a write
    t = tick_cnt;
    cpu_write(3'd5, 1'b1, 1'b0);
    cpu_write(3'd7, 1'b1, 1'b0);
    check("s5_bad_addr_rdata", cpu_if.cpu_rdata, 3'b000);
    expect_edge(t + 1, 3'b001);
    expect_edge(t + 65, 3'b000);
    cpu_write(3'd0, 1'b1, 1'b1);
    check("s5_clr_rdata", cpu_if.cpu_rdata, 3'b000);
    wait_until(t + 70);

    // 6: reset mid-trigger
    t = tick_cnt;
    expect_edge(t + 1, 3'b001);
    cpu_write(3'd0, 1'b1, 1'b0);
    wait_until(t + 10);
    check("s6_active", trig_en, 3'b001);
    #2 I_RSTn = 1'b0;
    #1;
    check("s6_async_drop", trig_en, 3'b000);
    check("s6_rdata_reset", cpu_if.cpu_rdata, 3'b000);
    repeat (3) @(negedge clk);
    #2 I_RSTn = 1'b1;
    t = tick_cnt;
    wait_until(t + 10);
    check("s6_no_refire", trig_en, 3'b000);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_edges actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
